// File: rtl/seq_alu_if.sv
// Request/result handshake bundle for seq_alu: operands and opcode in, registered result and flags out.
interface seq_alu_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cond_met;
   logic             zero_flag;
   logic             carry_flag;
   logic             ovf_flag;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, cond_met, zero_flag, carry_flag, ovf_flag
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, cond_met, zero_flag, carry_flag, ovf_flag
   );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU with Z/C/V flag registers, conditional arithmetic and valid/ready handshake.
// Define SEQ_ALU_MUL_EN to add the shift-add multiplier on op 29 (otherwise op 29 is unused).
module seq_alu #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic    clk,
   input  logic    rst_n,
   seq_alu_if.slave alu
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             condMet_q, condMet_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [SHW:0]     mulCnt_q, mulCnt_d;

   logic             accept;
   logic             launch;
   logic [WIDTH-1:0] addend;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic             arithV;
   logic [SHW-1:0]   shAmt;
   logic [WIDTH:0]   shlW, shrW, sarW;
   logic             condTrue;
   logic [WIDTH-1:0] exRes;
   logic [WIDTH-1:0] zeroSrc;
   logic             exCond, exWrZ, exWrC, exWrV, exC, exV;

`ifdef SEQ_ALU_MUL_EN
   localparam logic [SHW:0] MUL_STEPS = (SHW+1)'(WIDTH);
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] prodStep;

   // Classic shift-add: the multiplier sits in the low half and is consumed one bit per cycle.
   assign mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign prodStep = {mulSum, prod_q[WIDTH-1:1]};
`endif

   assign accept        = alu.in_valid & alu.in_ready;
   assign alu.in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & alu.out_ready));
   assign alu.out_valid = (state_q == DONE);
   assign alu.result    = result_q;
   assign alu.cond_met  = condMet_q;
   assign alu.zero_flag = zero_q;
   assign alu.carry_flag= carry_q;
   assign alu.ovf_flag  = ovf_q;

   // Extra bit on each side of the operand catches the last bit shifted out as carry.
   assign shAmt = alu.b[SHW-1:0];
   assign shlW  = {1'b0, alu.a} << shAmt;
   assign shrW  = {alu.a, 1'b0} >> shAmt;
   assign sarW  = $unsigned($signed({alu.a, 1'b0}) >>> shAmt);

   always_comb begin
      addend = alu.b;
      cin    = 1'b0;
      if (alu.op < 5'd20) begin
         case (alu.op[1:0])
            2'b00:   begin addend = alu.b;  cin = 1'b0;    end
            2'b01:   begin addend = ~alu.b; cin = 1'b1;    end
            2'b10:   begin addend = alu.b;  cin = carry_q; end
            default: begin addend = ~alu.b; cin = carry_q; end
         endcase
      end else if (alu.op == 5'd20) begin
         addend = WIDTH'(1);
      end else if (alu.op == 5'd21) begin
         addend = '1;
      end else if (alu.op == 5'd30) begin
         addend = ~alu.b;
         cin    = 1'b1;
      end
      sum    = {1'b0, alu.a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
      arithV = (alu.a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != alu.a[WIDTH-1]);
   end

   always_comb begin
      exRes   = '0;
      zeroSrc = '0;
      exCond  = 1'b0;
      exWrZ   = 1'b0;
      exWrC   = 1'b0;
      exWrV   = 1'b0;
      exC     = 1'b0;
      exV     = 1'b0;
      case (alu.op[4:2])
         3'd0:    condTrue = 1'b1;
         3'd1:    condTrue = zero_q;
         3'd2:    condTrue = ~zero_q;
         3'd3:    condTrue = carry_q;
         3'd4:    condTrue = ~carry_q;
         default: condTrue = 1'b0;
      endcase
      if (alu.op < 5'd20) begin
         exRes = alu.a;
         if (condTrue) begin
            exRes   = sum[WIDTH-1:0];
            zeroSrc = sum[WIDTH-1:0];
            exCond  = 1'b1;
            exWrZ   = 1'b1;
            exWrC   = 1'b1;
            exWrV   = 1'b1;
            exC     = sum[WIDTH];
            exV     = arithV;
         end
      end else begin
         case (alu.op)
            5'd20, 5'd21: begin
               exRes = sum[WIDTH-1:0]; zeroSrc = sum[WIDTH-1:0];
               exCond = 1'b1; exWrZ = 1'b1; exWrC = 1'b1; exWrV = 1'b1;
               exC = sum[WIDTH]; exV = arithV;
            end
            5'd22: begin exRes = alu.a & alu.b;    zeroSrc = exRes; exCond = 1'b1; exWrZ = 1'b1; end
            5'd23: begin exRes = ~(alu.a & alu.b); zeroSrc = exRes; exCond = 1'b1; exWrZ = 1'b1; end
            5'd24: begin exRes = alu.a | alu.b;    zeroSrc = exRes; exCond = 1'b1; exWrZ = 1'b1; end
            5'd25: begin exRes = alu.a ^ alu.b;    zeroSrc = exRes; exCond = 1'b1; exWrZ = 1'b1; end
            5'd26: begin
               exRes = shlW[WIDTH-1:0]; zeroSrc = exRes; exC = shlW[WIDTH];
               exCond = 1'b1; exWrZ = 1'b1; exWrC = 1'b1;
            end
            5'd27: begin
               exRes = shrW[WIDTH:1]; zeroSrc = exRes; exC = shrW[0];
               exCond = 1'b1; exWrZ = 1'b1; exWrC = 1'b1;
            end
            5'd28: begin
               exRes = sarW[WIDTH:1]; zeroSrc = exRes; exC = sarW[0];
               exCond = 1'b1; exWrZ = 1'b1; exWrC = 1'b1;
            end
            // Compare keeps operand a as the result; flags come from the discarded difference.
            5'd30: begin
               exRes = alu.a; zeroSrc = sum[WIDTH-1:0];
               exCond = 1'b1; exWrZ = 1'b1; exWrC = 1'b1; exWrV = 1'b1;
               exC = sum[WIDTH]; exV = arithV;
            end
            default: begin
               exRes = '0;
            end
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      condMet_d = condMet_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      mulCnt_d  = mulCnt_q;
      launch    = 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_d   = mcand_q;
      prod_d    = prod_q;
`endif
      case (state_q)
         IDLE: launch = accept;
         DONE: begin
            if (accept) begin
               launch = 1'b1;
            end else if (alu.out_ready) begin
               state_d = IDLE;
            end
         end
         EXEC: begin
`ifdef SEQ_ALU_MUL_EN
            mulCnt_d = mulCnt_q + 1'b1;
            prod_d   = prodStep;
            if (mulCnt_d == MUL_STEPS) begin
               state_d   = DONE;
               result_d  = prodStep[WIDTH-1:0];
               condMet_d = 1'b1;
               zero_d    = ~|prodStep[WIDTH-1:0];
               carry_d   = |prodStep[2*WIDTH-1:WIDTH];
               ovf_d     = 1'b0;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase

      // Single-cycle results land in DONE together with their flags on the accept edge.
      if (launch) begin
         state_d   = DONE;
         result_d  = exRes;
         condMet_d = exCond;
         if (exWrZ) zero_d  = ~|zeroSrc;
         if (exWrC) carry_d = exC;
         if (exWrV) ovf_d   = exV;
`ifdef SEQ_ALU_MUL_EN
         if (alu.op == 5'd29) begin
            state_d  = EXEC;
            mcand_d  = alu.a;
            prod_d   = {{WIDTH{1'b0}}, alu.b};
            mulCnt_d = '0;
         end
`endif
      end
   end

   // All architectural state clears asynchronously so an in-flight operation is simply dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         result_q  <= '0;
         condMet_q <= 1'b0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         mulCnt_q  <= '0;
`ifdef SEQ_ALU_MUL_EN
         mcand_q   <= '0;
         prod_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         condMet_q <= condMet_d;
         zero_q    <= zero_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         mulCnt_q  <= mulCnt_d;
`ifdef SEQ_ALU_MUL_EN
         mcand_q   <= mcand_d;
         prod_q    <= prod_d;
`endif
      end
   end

endmodule
